// File: rtl/ram8_16bit_regfile.sv
// Eight-entry register bank with one-hot write decode, registered 8:1 readback
// and a burst-write FSM that streams consecutive words into successive entries.
module ram8_16bit_regfile #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             burst_start,
    input  logic [2:0]       burst_len,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             burst_done,
    output logic [7:0]       written
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       ptr;
    logic [3:0]       remaining;
    logic             we;
    logic [2:0]       waddr;
    logic [7:0]       wsel;
    logic             last_word;

    always_comb begin
        next_state = state;
        we         = 1'b0;
        waddr      = address;
        last_word  = 1'b0;
        case (state)
            IDLE: begin
                // burst_start wins over a same-cycle load
                if (burst_start) next_state = BURST;
                else if (load)   we = 1'b1;
            end
            BURST: begin
                waddr = ptr;
                if (load) begin
                    we = 1'b1;
                    if (remaining == 4'd1) begin
                        last_word  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One-hot demux of the write strobe
    always_comb begin
        wsel = '0;
        if (we) wsel[waddr] = 1'b1;
    end

    assign busy = (state == BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            remaining  <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= last_word;
            if (state == IDLE && burst_start) begin
                ptr       <= address;
                remaining <= (burst_len == 3'd0) ? 4'd8 : {1'b0, burst_len};
            end else if (state == BURST && load) begin
                ptr       <= ptr + 3'd1;
                remaining <= remaining - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
            written <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++)
                if (wsel[i]) regs[i] <= in;
            written <= written | wsel;
        end
    end

    // Non-blocking update makes a same-cycle read see the pre-write value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            if (rd_en) out <= regs[rd_addr];
        end
    end

endmodule

// File: tb/tb_ram8_16bit_regfile.sv
// Scoreboard bench for ram8_16bit_regfile: reads push expected data into a queue,
// a forked monitor pops and compares whenever out_valid is seen.
module tb_ram8_16bit_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic [2:0]  address = '0;
    logic        burst_start = 1'b0;
    logic [2:0]  burst_len = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;
    logic        burst_done;
    logic [7:0]  written;

    ram8_16bit_regfile #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in(in), .load(load), .address(address),
        .burst_start(burst_start), .burst_len(burst_len), .rd_en(rd_en),
        .rd_addr(rd_addr), .out(out), .out_valid(out_valid), .busy(busy),
        .burst_done(burst_done), .written(written)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          bcnt   = 0;
    int          dcnt   = 0;
    logic [15:0] expq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (busy) bcnt++;
        if (burst_done) dcnt++;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp);
        rd_en = 1'b1; rd_addr = a; expq.push_back(exp);
        step();
        rd_en = 1'b0;
    endtask

    task automatic bload(input logic [15:0] d);
        in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    if (expq.size() == 0) chk("unexpected_read", {16'h0, out}, 32'hFFFF_FFFF);
                    else chk("read_data", {16'h0, out}, {16'h0, expq.pop_front()});
                end
            end
        join_none

        // T1: asynchronous reset with no clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_out", {16'h0, out}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, burst_done}, 32'h0);
        chk("rst_written", {24'h0, written}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000);

        // T2: single writes
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
        for (int i = 0; i < 8; i++) rd(3'(i), 16'(16'h1111 * i));
        chk("t2_written", {24'h0, written}, 32'hFF);

        // T3: read-before-write collision
        wr(3'd3, 16'hAAAA);
        address = 3'd3; in = 16'h5555; load = 1'b1;
        rd_en = 1'b1; rd_addr = 3'd3; expq.push_back(16'hAAAA);
        step();
        load = 1'b0; rd_en = 1'b0;
        rd(3'd3, 16'h5555);

        // T4: wrapping burst with a stall
        bcnt = 0; dcnt = 0;
        burst_start = 1'b1; address = 3'd6; burst_len = 3'd4;
        step();
        burst_start = 1'b0; address = 3'd0;
        bload(16'hF006);
        bload(16'hF007);
        step();
        bload(16'hF000);
        bload(16'hF001);
        chk("t4_busy_after", {31'h0, busy}, 32'h0);
        chk("t4_done_pulse", {31'h0, burst_done}, 32'h1);
        step();
        chk("t4_busy_cycles", bcnt, 5);
        chk("t4_done_count", dcnt, 1);
        rd(3'd6, 16'hF006); rd(3'd7, 16'hF007); rd(3'd0, 16'hF000); rd(3'd1, 16'hF001);
        rd(3'd2, 16'h2222); rd(3'd3, 16'h5555); rd(3'd4, 16'h4444); rd(3'd5, 16'h5555);

        // T5: burst_start priority and len=0 meaning 8
        bcnt = 0; dcnt = 0;
        burst_start = 1'b1; load = 1'b1; in = 16'hDEAD; address = 3'd2; burst_len = 3'd0;
        step();
        burst_start = 1'b0; load = 1'b0;
        chk("t5_busy", {31'h0, busy}, 32'h1);
        rd(3'd2, 16'h2222);
        for (int k = 0; k < 8; k++) begin
            address = 3'd7;
            bload(16'(16'hB000 + k));
        end
        chk("t5_busy_after8", {31'h0, busy}, 32'h0);
        wr(3'd5, 16'hC0DE);
        chk("t5_done_count", dcnt, 1);
        rd(3'd2, 16'hB000); rd(3'd3, 16'hB001); rd(3'd4, 16'hB002); rd(3'd5, 16'hC0DE);
        rd(3'd6, 16'hB004); rd(3'd7, 16'hB005); rd(3'd0, 16'hB006); rd(3'd1, 16'hB007);

        // T6: reset mid-burst
        dcnt = 0;
        burst_start = 1'b1; address = 3'd0; burst_len = 3'd5;
        step();
        burst_start = 1'b0;
        bload(16'h0101);
        bload(16'h0202);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_written", {24'h0, written}, 32'h0);
        chk("t6_out", {16'h0, out}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        step(); step();
        chk("t6_no_done", dcnt, 0);
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000);
        wr(3'd4, 16'h1234);
        rd(3'd4, 16'h1234);
        chk("t6_written_after", {24'h0, written}, 32'h10);

        step(); step();
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
